// File: rtl/axi4lite_debug_regs_if.sv
// AXI4-Lite bus bundle for the debug register block.
// Signal names match the s00_axi_* port names of the responder.
interface axi4lite_debug_regs_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   s00_axi_awaddr;
  logic [2:0]          s00_axi_awprot;
  logic                s00_axi_awvalid;
  logic                s00_axi_awready;
  logic [DATA_W-1:0]   s00_axi_wdata;
  logic [DATA_W/8-1:0] s00_axi_wstrb;
  logic                s00_axi_wvalid;
  logic                s00_axi_wready;
  logic [1:0]          s00_axi_bresp;
  logic                s00_axi_bvalid;
  logic                s00_axi_bready;
  logic [ADDR_W-1:0]   s00_axi_araddr;
  logic [2:0]          s00_axi_arprot;
  logic                s00_axi_arvalid;
  logic                s00_axi_arready;
  logic [DATA_W-1:0]   s00_axi_rdata;
  logic [1:0]          s00_axi_rresp;
  logic                s00_axi_rvalid;
  logic                s00_axi_rready;

  modport slave (
    input  s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
    output s00_axi_awready,
    input  s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
    output s00_axi_wready,
    output s00_axi_bresp, s00_axi_bvalid,
    input  s00_axi_bready,
    input  s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
    output s00_axi_arready,
    output s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
    input  s00_axi_rready
  );

  modport master (
    output s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
    input  s00_axi_awready,
    output s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
    input  s00_axi_wready,
    input  s00_axi_bresp, s00_axi_bvalid,
    output s00_axi_bready,
    output s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
    input  s00_axi_arready,
    input  s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
    output s00_axi_rready
  );
endinterface

// File: rtl/axi4lite_debug_regs.sv
// AXI4-Lite debug register file: ID, SCRATCH0/1, CTRL, W1C STATUS, optional COUNTER.
// Define AXI_REGS_COUNTER_EN to implement the free-running COUNTER at offset 0x14.
module axi4lite_debug_regs #(
  parameter int          C_S00_AXI_ADDR_WIDTH = 32,
  parameter int          C_S00_AXI_DATA_WIDTH = 32,
  parameter logic [31:0] C_ID                 = 32'h52454753
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  axi4lite_debug_regs_if.slave            s_axi,
  output logic [C_S00_AXI_DATA_WIDTH-1:0] ctrl_out,
  input  logic                            event_in,
  output logic                            irq
);
  localparam int DW = C_S00_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int AW = C_S00_AXI_ADDR_WIDTH;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic          awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic          bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]    bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [2:0]    aw_idx_q, aw_idx_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic [DW-1:0] scratch0_q, scratch0_d, scratch1_q, scratch1_d, ctrl_q, ctrl_d;
  logic          status_q, status_d, event_prev_q, irq_q, irq_d;
`ifdef AXI_REGS_COUNTER_EN
  logic [DW-1:0] counter_q, counter_d;
`endif

  logic          aw_hs, w_hs, ar_hs, commit, wr_err, rd_err, ev_rise, w1c;
  logic [2:0]    wr_idx, rd_idx;
  logic [DW-1:0] wr_data, rd_val;
  logic [SW-1:0] wr_strb;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                          input logic [DW-1:0] new_v,
                                          input logic [SW-1:0] strb);
    logic [DW-1:0] r;
    r = old_v;
    for (int b = 0; b < SW; b++)
      if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  // Write path: each channel is latched on its own handshake; the commit uses
  // whichever of held/incoming copy is current so same-cycle arrival also commits.
  always_comb begin
    aw_hs   = s_axi.s00_axi_awvalid & awready_q;
    w_hs    = s_axi.s00_axi_wvalid & wready_q;
    wr_idx  = aw_hs ? s_axi.s00_axi_awaddr[4:2] : aw_idx_q;
    wr_data = w_hs ? s_axi.s00_axi_wdata : wdata_q;
    wr_strb = w_hs ? s_axi.s00_axi_wstrb : wstrb_q;
    commit  = (aw_held_q | aw_hs) & (w_held_q | w_hs) & ~bvalid_q;
    wr_err  = !(wr_idx inside {3'd1, 3'd2, 3'd3, 3'd4});

    aw_held_d = commit ? 1'b0 : (aw_held_q | aw_hs);
    w_held_d  = commit ? 1'b0 : (w_held_q | w_hs);
    aw_idx_d  = wr_idx;
    wdata_d   = wr_data;
    wstrb_d   = wr_strb;
    bvalid_d  = commit | (bvalid_q & ~s_axi.s00_axi_bready);
    bresp_d   = commit ? (wr_err ? SLVERR : OKAY) : bresp_q;
    awready_d = ~(aw_held_d | bvalid_d);
    wready_d  = ~(w_held_d | bvalid_d);

    scratch0_d = (commit && wr_idx == 3'd1) ? merge(scratch0_q, wr_data, wr_strb) : scratch0_q;
    scratch1_d = (commit && wr_idx == 3'd2) ? merge(scratch1_q, wr_data, wr_strb) : scratch1_q;
    ctrl_d     = (commit && wr_idx == 3'd3) ? merge(ctrl_q, wr_data, wr_strb) : ctrl_q;

    // A fresh event outranks a same-edge W1C so no edge is ever lost.
    ev_rise  = event_in & ~event_prev_q;
    w1c      = commit && wr_idx == 3'd4 && wr_strb[0] && wr_data[0];
    status_d = ev_rise | (status_q & ~w1c);
    irq_d    = status_q & ctrl_q[DW-1];
`ifdef AXI_REGS_COUNTER_EN
    counter_d = counter_q + {{(DW-1){1'b0}}, 1'b1};
`endif
  end

  // Read path samples current register values, so a same-edge write is not seen.
  always_comb begin
    ar_hs  = s_axi.s00_axi_arvalid & arready_q;
    rd_idx = s_axi.s00_axi_araddr[4:2];
    rd_val = '0;
    rd_err = 1'b0;
    case (rd_idx)
      3'd0:    rd_val = C_ID;
      3'd1:    rd_val = scratch0_q;
      3'd2:    rd_val = scratch1_q;
      3'd3:    rd_val = ctrl_q;
      3'd4:    rd_val = {{(DW-1){1'b0}}, status_q};
`ifdef AXI_REGS_COUNTER_EN
      3'd5:    rd_val = counter_q;
`endif
      default: rd_err = 1'b1;
    endcase
    rvalid_d  = ar_hs | (rvalid_q & ~s_axi.s00_axi_rready);
    arready_d = ~rvalid_d;
    rdata_d   = ar_hs ? (rd_err ? '0 : rd_val) : rdata_q;
    rresp_d   = ar_hs ? (rd_err ? SLVERR : OKAY) : rresp_q;
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      arready_q    <= 1'b0;
      bvalid_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      bresp_q      <= '0;
      rresp_q      <= '0;
      rdata_q      <= '0;
      aw_held_q    <= 1'b0;
      w_held_q     <= 1'b0;
      aw_idx_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      scratch0_q   <= '0;
      scratch1_q   <= '0;
      ctrl_q       <= '0;
      status_q     <= 1'b0;
      event_prev_q <= 1'b0;
      irq_q        <= 1'b0;
`ifdef AXI_REGS_COUNTER_EN
      counter_q    <= '0;
`endif
    end else begin
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      arready_q    <= arready_d;
      bvalid_q     <= bvalid_d;
      rvalid_q     <= rvalid_d;
      bresp_q      <= bresp_d;
      rresp_q      <= rresp_d;
      rdata_q      <= rdata_d;
      aw_held_q    <= aw_held_d;
      w_held_q     <= w_held_d;
      aw_idx_q     <= aw_idx_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      scratch0_q   <= scratch0_d;
      scratch1_q   <= scratch1_d;
      ctrl_q       <= ctrl_d;
      status_q     <= status_d;
      event_prev_q <= event_in;
      irq_q        <= irq_d;
`ifdef AXI_REGS_COUNTER_EN
      counter_q    <= counter_d;
`endif
    end
  end

  assign s_axi.s00_axi_awready = awready_q;
  assign s_axi.s00_axi_wready  = wready_q;
  assign s_axi.s00_axi_arready = arready_q;
  assign s_axi.s00_axi_bvalid  = bvalid_q;
  assign s_axi.s00_axi_bresp   = bresp_q;
  assign s_axi.s00_axi_rvalid  = rvalid_q;
  assign s_axi.s00_axi_rresp   = rresp_q;
  assign s_axi.s00_axi_rdata   = rdata_q;
  assign ctrl_out = ctrl_q;
  assign irq      = irq_q;

  logic unused_ok;
  assign unused_ok = ^{s_axi.s00_axi_awaddr[AW-1:5], s_axi.s00_axi_awaddr[1:0],
                       s_axi.s00_axi_araddr[AW-1:5], s_axi.s00_axi_araddr[1:0],
                       s_axi.s00_axi_awprot, s_axi.s00_axi_arprot};
endmodule

// File: tb/tb_axi4lite_debug_regs.sv
// Bench for axi4lite_debug_regs: directed sequences, a vector table and
// randomized traffic checked against a register-map model.
module tb_axi4lite_debug_regs;
  localparam logic [31:0] ID = 32'h52454753;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        event_in = 1'b0;
  logic        irq;
  logic [31:0] ctrl_out;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi4lite_debug_regs_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi4lite_debug_regs #(.C_S00_AXI_ADDR_WIDTH(32), .C_S00_AXI_DATA_WIDTH(32), .C_ID(ID)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .s_axi(bus),
    .ctrl_out(ctrl_out), .event_in(event_in), .irq(irq)
  );

  // Register-map model: what each offset holds and which accesses are legal.
  logic [31:0] m_s0, m_s1, m_ctrl;
  logic        m_stat;

  function automatic void m_reset();
    m_s0 = 0; m_s1 = 0; m_ctrl = 0; m_stat = 0;
  endfunction

  function automatic logic [1:0] m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    case (a[4:2])
      3'd1: m_s0   = (m_s0 & ~mask) | (d & mask);
      3'd2: m_s1   = (m_s1 & ~mask) | (d & mask);
      3'd3: m_ctrl = (m_ctrl & ~mask) | (d & mask);
      3'd4: if (s[0] && d[0]) m_stat = 1'b0;
      default: return 2'b10;
    endcase
    return 2'b00;
  endfunction

  // Returns 1 when the data value is predictable (COUNTER is not).
  function automatic bit m_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    d = 0; r = 2'b00;
    case (a[4:2])
      3'd0: d = ID;
      3'd1: d = m_s0;
      3'd2: d = m_s1;
      3'd3: d = m_ctrl;
      3'd4: d = {31'd0, m_stat};
`ifdef AXI_REGS_COUNTER_EN
      3'd5: return 1'b0;
`endif
      default: r = 2'b10;
    endcase
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All bus tasks start and end just after a rising edge.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit aw_p = 1, w_p = 1, aw_go, w_go, got = 0;
    resp = 2'b11;
    bus.s00_axi_awaddr = a; bus.s00_axi_awvalid = 1'b1;
    bus.s00_axi_wdata = d; bus.s00_axi_wstrb = s; bus.s00_axi_wvalid = 1'b1;
    bus.s00_axi_bready = 1'b1;
    for (int n = 0; n < 20 && (aw_p || w_p); n++) begin
      @(negedge clk);
      aw_go = aw_p && bus.s00_axi_awready;
      w_go  = w_p && bus.s00_axi_wready;
      @(posedge clk); #1;
      if (aw_go) begin bus.s00_axi_awvalid = 1'b0; aw_p = 0; end
      if (w_go)  begin bus.s00_axi_wvalid = 1'b0; w_p = 0; end
    end
    if (aw_p || w_p) begin
      chk("wr_accept_timeout", 1, 0);
      bus.s00_axi_awvalid = 1'b0; bus.s00_axi_wvalid = 1'b0;
    end
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (bus.s00_axi_bvalid) begin resp = bus.s00_axi_bresp; got = 1; end
      @(posedge clk); #1;
    end
    if (!got) chk("bvalid_timeout", 0, 1);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output int unsigned hs_cyc);
    bit acc = 0, got = 0;
    int waited = 0;
    d = 32'hx; resp = 2'b11; hs_cyc = 0;
    bus.s00_axi_araddr = a; bus.s00_axi_arvalid = 1'b1; bus.s00_axi_rready = 1'b1;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      acc = bus.s00_axi_arready;
      @(posedge clk); #1;
      if (acc) begin bus.s00_axi_arvalid = 1'b0; hs_cyc = cyc; end
    end
    if (!acc) begin chk("ar_accept_timeout", 1, 0); bus.s00_axi_arvalid = 1'b0; end
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      waited++;
      if (bus.s00_axi_rvalid) begin d = bus.s00_axi_rdata; resp = bus.s00_axi_rresp; got = 1; end
      @(posedge clk); #1;
    end
    if (!got) chk("rvalid_timeout", 0, 1);
    else if (waited != 1) chk("rd_latency", waited, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.s00_axi_awvalid = 0; bus.s00_axi_wvalid = 0; bus.s00_axi_arvalid = 0;
    bus.s00_axi_bready = 1; bus.s00_axi_rready = 1; event_in = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        {bus.s00_axi_awready, bus.s00_axi_wready, bus.s00_axi_arready, bus.s00_axi_bvalid,
         bus.s00_axi_rvalid, irq, bus.s00_axi_bresp, bus.s00_axi_rresp, bus.s00_axi_rdata, ctrl_out},
        0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready_after_reset", {bus.s00_axi_awready, bus.s00_axi_wready, bus.s00_axi_arready}, 3'b111);
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [1:0]  er;
    logic [31:0] ed;
  } vec_t;
  vec_t tv[20];

  logic [31:0] rd, rd2;
  logic [1:0]  rs;
  int unsigned hc, hc2;

  initial begin
    tv[0]  = '{1, 32'hFFFF_FF00, 32'hDEAD_BEEF, 4'hF, 2'b10, 32'h0};
    tv[1]  = '{1, 32'h0000_001C, 32'h0000_0001, 4'hF, 2'b10, 32'h0};
    tv[2]  = '{0, 32'h0000_0000, 32'h0,         4'h0, 2'b00, ID};
    tv[3]  = '{0, 32'h0000_001C, 32'h0,         4'h0, 2'b10, 32'h0};
    tv[4]  = '{1, 32'h0000_0008, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0};
    tv[5]  = '{0, 32'hABC0_0008, 32'h0,         4'h0, 2'b00, 32'hFFFF_FFFF};
    tv[6]  = '{1, 32'h0000_0008, 32'h0,         4'h0, 2'b00, 32'h0};
    tv[7]  = '{0, 32'h0000_0008, 32'h0,         4'h0, 2'b00, 32'hFFFF_FFFF};
    tv[8]  = '{1, 32'h0000_000B, 32'h1234_5678, 4'h8, 2'b00, 32'h0};
    tv[9]  = '{0, 32'h0000_0008, 32'h0,         4'h0, 2'b00, 32'h12FF_FFFF};
    tv[10] = '{0, 32'h0000_0010, 32'h0,         4'h0, 2'b00, 32'h0};
    tv[11] = '{1, 32'h0000_0014, 32'h0000_0001, 4'hF, 2'b10, 32'h0};
`ifdef AXI_REGS_COUNTER_EN
    tv[12] = '{1, 32'h0000_0000, 32'h0000_0000, 4'hF, 2'b10, 32'h0};
`else
    tv[12] = '{0, 32'h0000_0014, 32'h0,         4'h0, 2'b10, 32'h0};
`endif
    tv[13] = '{0, 32'h0000_0018, 32'h0,         4'h0, 2'b10, 32'h0};
    tv[14] = '{1, 32'h0000_000C, 32'h0000_00FF, 4'h3, 2'b00, 32'h0};
    tv[15] = '{0, 32'h0000_000C, 32'h0,         4'h0, 2'b00, 32'h0000_00FF};
    tv[16] = '{1, 32'h0000_0004, 32'h1111_2222, 4'hC, 2'b00, 32'h0};
    tv[17] = '{0, 32'h0000_0004, 32'h0,         4'h0, 2'b00, 32'h1111_0000};
    tv[18] = '{1, 32'h0000_0018, 32'h5555_5555, 4'hF, 2'b10, 32'h0};
    tv[19] = '{0, 32'hFFFF_FFE0, 32'h0,         4'h0, 2'b00, ID};

    bus.s00_axi_awaddr = 0; bus.s00_axi_awprot = 0; bus.s00_axi_wdata = 0; bus.s00_axi_wstrb = 0;
    bus.s00_axi_araddr = 0; bus.s00_axi_arprot = 0;
    do_reset();

    axi_read(32'h0, rd, rs, hc);
    chk("id_rdata", rd, ID);
    chk("id_rresp", rs, 2'b00);

    // AW two cycles ahead of W; commit happens on the W edge.
    bus.s00_axi_awaddr = 32'h4; bus.s00_axi_awvalid = 1;
    @(negedge clk); chk("aw_first_ready", bus.s00_axi_awready, 1);
    @(posedge clk); #1; bus.s00_axi_awvalid = 0;
    repeat (2) begin
      @(negedge clk);
      chk("aw_held_state", {bus.s00_axi_awready, bus.s00_axi_wready, bus.s00_axi_bvalid}, 3'b010);
      @(posedge clk); #1;
    end
    bus.s00_axi_wdata = 32'hA5A5_1234; bus.s00_axi_wstrb = 4'b0101; bus.s00_axi_wvalid = 1;
    @(negedge clk); @(posedge clk); #1; bus.s00_axi_wvalid = 0;
    @(negedge clk); chk("split_bresp", {bus.s00_axi_bvalid, bus.s00_axi_bresp}, 3'b100);
    @(posedge clk); #1;
    axi_read(32'h4, rd, rs, hc);
    chk("split_rdback", rd, 32'h00A5_0034);

    // Back-pressured write response.
    bus.s00_axi_bready = 0;
    bus.s00_axi_awaddr = 32'hC; bus.s00_axi_awvalid = 1;
    bus.s00_axi_wdata = 32'h8000_0001; bus.s00_axi_wstrb = 4'hF; bus.s00_axi_wvalid = 1;
    @(negedge clk); @(posedge clk); #1;
    bus.s00_axi_awvalid = 0; bus.s00_axi_wvalid = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bhold_state", {bus.s00_axi_bvalid, bus.s00_axi_bresp, bus.s00_axi_awready, bus.s00_axi_wready}, 5'b10000);
      chk("bhold_ctrl_out", ctrl_out, 32'h8000_0001);
      @(posedge clk); #1;
    end
    bus.s00_axi_bready = 1;
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk);
    chk("bhold_release", {bus.s00_axi_bvalid, bus.s00_axi_awready, bus.s00_axi_wready}, 3'b011);
    @(posedge clk); #1;

    // Event / W1C / irq.
    axi_write(32'hC, 32'h8000_0000, 4'hF, rs);
    @(negedge clk); chk("irq_idle", irq, 0); @(posedge clk); #1;
    event_in = 1; @(posedge clk); #1; event_in = 0;
    repeat (2) @(posedge clk); #1;
    axi_read(32'h10, rd, rs, hc);
    chk("status_set", rd, 1);
    @(negedge clk); chk("irq_set", irq, 1); @(posedge clk); #1;
    event_in = 1;
    axi_write(32'h10, 32'h1, 4'h1, rs);
    event_in = 0;
    axi_read(32'h10, rd, rs, hc);
    chk("status_set_wins", rd, 1);
    axi_write(32'h10, 32'h1, 4'h1, rs);
    chk("w1c_bresp", rs, 2'b00);
    axi_read(32'h10, rd, rs, hc);
    chk("status_cleared", rd, 0);
    @(negedge clk); chk("irq_cleared", irq, 0); @(posedge clk); #1;

`ifdef AXI_REGS_COUNTER_EN
    axi_read(32'h14, rd, rs, hc);
    repeat (7) @(posedge clk); #1;
    axi_read(32'h14, rd2, rs, hc2);
    chk("counter_delta", rd2 - rd, hc2 - hc);
    chk("counter_rresp", rs, 2'b00);
`endif

    do_reset();
    m_reset();
    for (int i = 0; i < 20; i++) begin
      if (tv[i].wr) begin
        axi_write(tv[i].a, tv[i].d, tv[i].s, rs);
        void'(m_write(tv[i].a, tv[i].d, tv[i].s));
        chk($sformatf("tv%0d_bresp", i), rs, tv[i].er);
      end else begin
        axi_read(tv[i].a, rd, rs, hc);
        chk($sformatf("tv%0d_rresp", i), rs, tv[i].er);
        chk($sformatf("tv%0d_rdata", i), rd, tv[i].ed);
      end
    end

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, d, ed;
      logic [3:0]  s;
      logic [1:0]  er;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; s = 4'($urandom_range(0, 15));
        axi_write(a, d, s, rs);
        er = m_write(a, d, s);
        chk($sformatf("rnd%0d_bresp", i), rs, er);
        chk($sformatf("rnd%0d_ctrl_out", i), ctrl_out, m_ctrl);
      end else begin
        axi_read(a, rd, rs, hc);
        if (m_read(a, ed, er)) chk($sformatf("rnd%0d_rdata", i), rd, ed);
        chk($sformatf("rnd%0d_rresp", i), rs, er);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
